uart_rx_fifo_gen2: RTL and testbench

//  Parametrised next-generation UART receiver: oversampled, 3-sample majority vote, 1/2 stop bits, optional parity.

---
 rtl/uart_rx_fifo_gen2.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo_gen2.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_gen2.sv
// Oversampled UART receiver (majority vote, optional parity, 1/2 stop bits) feeding a
// show-ahead FIFO with valid/ready read side, plus overrun and break pulses.
module uart_rx_fifo_gen2 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRESC_W    = 6
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [PRESC_W-1:0]            PRESCALAR,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    input  logic                          RX_IN,
    output logic [DATA_WIDTH-1:0]         RX_DATA,
    output logic                          RX_PAR_ERR,
    output logic                          RX_STP_ERR,
    output logic                          RX_VALID,
    input  logic                          RX_READY,
    output logic                          OVERRUN,
    output logic                          BREAK_DET,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned ENT_W = DATA_WIDTH + 2;

    localparam logic [PRESC_W-1:0] P_ONE   = PRESC_W'(1);
    localparam logic [CNT_W-1:0]   C_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
    localparam logic [BIT_W-1:0]   B_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]   B_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]   C_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [PRESC_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_err_q, par_err_d;
    logic                    stp_err_q, stp_err_d;
    logic                    s0_q, s0_d, s1_q, s1_d;
    logic                    wait_high_q, wait_high_d;
    logic [PRESC_W-1:0]      p_q, p_d;
    logic                    par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;

    logic                    rx_s, maj, at_s0, at_s1, at_samp, at_end;
    logic [PRESC_W-1:0]      half;
    logic                    commit, brk;
    logic [ENT_W-1:0]        entry;

    assign rx_s    = sync2_q;
    assign half    = {1'b0, p_q[PRESC_W-1:1]};
    assign at_s0   = (edge_cnt_q == half - P_ONE);
    assign at_s1   = (edge_cnt_q == half);
    assign at_samp = (edge_cnt_q == half + P_ONE);
    assign at_end  = (edge_cnt_q == p_q - P_ONE);
    assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        par_err_d   = par_err_q;
        stp_err_d   = stp_err_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        wait_high_d = wait_high_q;
        p_d         = p_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        stop2_d     = stop2_q;
        commit      = 1'b0;
        brk         = 1'b0;
        entry       = {par_err_q, stp_err_q | ~maj, data_q};

        if (state_q != StIdle) begin
            edge_cnt_d = at_end ? '0 : edge_cnt_q + P_ONE;
            if (at_s0) s0_d = rx_s;
            if (at_s1) s1_d = rx_s;
        end

        unique case (state_q)
            StIdle: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (wait_high_q) begin
                    if (rx_s) wait_high_d = 1'b0;
                end else if (!rx_s) begin
                    state_d   = StStart;
                    p_d       = PRESCALAR;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            StStart: begin
                if (at_samp && maj) begin
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end else if (at_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_samp) data_d = {maj, data_q[DATA_WIDTH-1:1]};
                if (at_end) begin
                    if (bit_cnt_q == B_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + B_ONE;
                    end
                end
            end
            StParity: begin
                if (at_samp) par_err_d = (maj != (^data_q ^ par_typ_q));
                if (at_end) state_d = StStop;
            end
            StStop: begin
                if (at_samp) begin
                    if (!maj) stp_err_d = 1'b1;
                    // bit_cnt marks which stop bit we are in; commit mid final stop bit
                    if (!(stop2_q && bit_cnt_q == '0)) begin
                        commit     = 1'b1;
                        brk        = (data_q == '0) && !maj;
                        state_d    = StIdle;
                        edge_cnt_d = '0;
                        bit_cnt_d  = '0;
                        if (brk) wait_high_d = 1'b1;
                    end
                end else if (at_end) begin
                    bit_cnt_d = B_ONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            edge_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            stp_err_q   <= 1'b0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            wait_high_q <= 1'b0;
            p_q         <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            stop2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= RX_IN;
            sync2_q     <= sync1_q;
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            stp_err_q   <= stp_err_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            wait_high_q <= wait_high_d;
            p_q         <= p_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            stop2_q     <= stop2_d;
        end
    end

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, remaining;
    logic [ENT_W-1:0] head_q, head_d;
    logic             valid_q, ovr_q, brk_q;
    logic             push, pop, full;

    assign full = (count_q == C_FULL);
    assign push = commit && !brk && !full;
    assign pop  = valid_q && RX_READY;

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        remaining = pop ? count_q - C_ONE : count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
        head_d = head_q;
        // when the FIFO drains to empty this cycle, the incoming frame becomes the head directly
        if (remaining == '0) begin
            if (push) head_d = entry;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= entry;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
            ovr_q    <= commit && !brk && full;
            brk_q    <= brk;
        end
    end

    assign RX_DATA    = head_q[DATA_WIDTH-1:0];
    assign RX_STP_ERR = head_q[DATA_WIDTH];
    assign RX_PAR_ERR = head_q[DATA_WIDTH+1];
    assign RX_VALID   = valid_q;
    assign OVERRUN    = ovr_q;
    assign BREAK_DET  = brk_q;
    assign FIFO_LEVEL = count_q;

endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// Scoreboard bench for uart_rx_fifo_gen2: directed frames push expected {par,stp,data};
// a negedge monitor compares each popped head entry and counts overrun/break pulses.
module tb_uart_rx_fifo_gen2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] PRESCALAR = 6'd16;
    logic       PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
    logic       RX_IN = 1'b1;
    logic       RX_READY = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_PAR_ERR, RX_STP_ERR, RX_VALID, OVERRUN, BREAK_DET;
    logic [2:0] FIFO_LEVEL;

    uart_rx_fifo_gen2 #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PRESCALAR  (PRESCALAR),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .RX_IN      (RX_IN),
        .RX_DATA    (RX_DATA),
        .RX_PAR_ERR (RX_PAR_ERR),
        .RX_STP_ERR (RX_STP_ERR),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .OVERRUN    (OVERRUN),
        .BREAK_DET  (BREAK_DET),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    logic [9:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;

    // Monitor: pop happens at the next rising edge whenever valid&ready is seen here.
    always @(negedge CLK) begin
        if (!RST) begin
            if (OVERRUN) ovr_cnt++;
            if (BREAK_DET) brk_cnt++;
            if (RX_VALID && RX_READY) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_entry got=%h (none expected)",
                             {RX_PAR_ERR, RX_STP_ERR, RX_DATA});
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({RX_PAR_ERR, RX_STP_ERR, RX_DATA} !== e) begin
                        fails++;
                        $display("FAIL entry got=%h required=%h",
                                 {RX_PAR_ERR, RX_STP_ERR, RX_DATA}, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                        input logic pbit, input logic s1, input logic s2en, input logic s2);
        PRESCALAR = 6'(p);
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        STOP2     = s2en;
        hold(1'b0, p);
        for (int i = 0; i < 8; i++) hold(d[i], p);
        if (pen) hold(pbit, p);
        hold(s1, p);
        if (s2en) hold(s2, p);
        hold(1'b1, 2 * p);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || RX_VALID) && t < 2000) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_level"}, FIFO_LEVEL, 0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_valid", RX_VALID, 0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_data", RX_DATA, 0);
        check("rst_flags", {RX_PAR_ERR, RX_STP_ERR}, 0);
        check("rst_pulses", {OVERRUN, BREAK_DET}, 0);
        hold(1'b1, 20);

        // 8N1 at P=16
        exp_q.push_back({2'b00, 8'hA5});
        send(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain("a5");

        // P=8 parity: 0x3C has even weight, so parity bit 1 is wrong for even, right for odd
        exp_q.push_back({2'b10, 8'h3C});
        send(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("par_even");
        exp_q.push_back({2'b00, 8'h3C});
        send(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("par_odd");

        // short low glitch rejected by start-bit majority
        PRESCALAR = 6'd16;
        PAR_EN = 1'b0;
        hold(1'b0, 4);
        hold(1'b1, 40);
        check("glitch_valid", RX_VALID, 0);
        check("glitch_level", FIFO_LEVEL, 0);
        exp_q.push_back({2'b00, 8'h55});
        send(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain("after_glitch");

        // overrun: fill 4-deep FIFO with the consumer stalled
        RX_READY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({2'b00, 8'(i)});
            send(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("ovr_level", FIFO_LEVEL, 4);
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_head", RX_DATA, 8'h01);
        RX_READY = 1'b1;
        drain("ovr");

        // two stop bits, second one low
        exp_q.push_back({2'b01, 8'h5A});
        send(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain("stop2");

        // break: all-zero frame with low stop bit
        send(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("brk_pulses", brk_cnt, 1);
        check("brk_level", FIFO_LEVEL, 0);
        exp_q.push_back({2'b00, 8'h42});
        send(8'h42, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain("after_brk");

        // reset in the middle of the data bits of 0xFF
        PRESCALAR = 6'd16;
        hold(1'b0, 16);
        hold(1'b1, 48);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        hold(1'b1, 16 * 8);
        check("midrst_valid", RX_VALID, 0);
        check("midrst_level", FIFO_LEVEL, 0);
        exp_q.push_back({2'b00, 8'h81});
        send(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain("after_rst");

        check("final_ovr", ovr_cnt, 1);
        check("final_brk", brk_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
